// File: rtl/color_correct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : color_correct_pkg
// Description : Shared definitions for the colour-correction-matrix stage:
//               beat-type encoding of the pixel stream, the coefficient
//               index constants (row = output channel, col = input channel)
//               and small helpers used to build the identity bank.
// Revision    : 1.0 - initial release
// ============================================================================
package color_correct_pkg;

    // Beat-type encoding of the video side channel (one-hot by class).
    localparam int             DTYPE_WIDTH       = 8;
    localparam logic [7:0]     DTYPE_FRAME_START = 8'h01;
    localparam logic [7:0]     DTYPE_FRAME_END   = 8'h02;
    localparam logic [7:0]     DTYPE_ROW_START   = 8'h04;
    localparam logic [7:0]     DTYPE_ROW_END     = 8'h08;
    localparam logic [7:0]     DTYPE_HEADER      = 8'h10;
    localparam logic [7:0]     DTYPE_PIXEL       = 8'h20;
    localparam logic [7:0]     DTYPE_PIXEL_MASK  = 8'h20;

    // Coefficient element index = 3*row + col.
    localparam int CCM_R_R = 0;
    localparam int CCM_R_G = 1;
    localparam int CCM_R_B = 2;
    localparam int CCM_G_R = 3;
    localparam int CCM_G_G = 4;
    localparam int CCM_G_B = 5;
    localparam int CCM_B_R = 6;
    localparam int CCM_B_G = 7;
    localparam int CCM_B_B = 8;

    function automatic int ccm_idx(input int row, input int col);
        return 3 * row + col;
    endfunction

    function automatic bit ccm_is_diag(input int idx);
        return (idx == CCM_R_R) || (idx == CCM_G_G) || (idx == CCM_B_B);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccm_channel.sv
`default_nettype none
// ============================================================================
// Module      : ccm_channel
// Description : One output channel of the 3x3 colour matrix.
//               S1: three signed products registered.
//               S2: sum of products plus rounding constant registered.
//               S3: arithmetic shift, optional offset, clamp; output register
//                   only loads when the beat in S2 is a pixel (hold otherwise).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_x[3]              - unsigned input channels (r,g,b)
//               i_coef[3]           - signed coefficients for this row
//               i_off               - signed offset (COLOR_CORRECT_OFFSET_EN)
//               i_load              - S2 beat is a valid pixel
//               o_pix               - clamped output channel
// Config      : COLOR_CORRECT_OFFSET_EN adds the i_off port and adder.
// Revision    : 1.0 - initial release
// ============================================================================
module ccm_channel
    import color_correct_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int COEF_WIDTH  = 12,
    parameter int COEF_FRAC   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2:0][PIXEL_WIDTH-1:0]       i_x,
    input  logic [2:0][COEF_WIDTH-1:0]        i_coef,
`ifdef COLOR_CORRECT_OFFSET_EN
    input  logic [PIXEL_WIDTH:0]              i_off,
`endif
    input  logic                              i_load,
    output logic [PIXEL_WIDTH-1:0]            o_pix
);

    localparam int c_PW = PIXEL_WIDTH + COEF_WIDTH + 1;  // product width
    localparam int c_SW = c_PW + 2;                       // sum width
    localparam logic signed [c_SW-1:0] c_ROUND = c_SW'(1) << (COEF_FRAC - 1);
    localparam logic signed [c_SW-1:0] c_MAX   = c_SW'((1 << PIXEL_WIDTH) - 1);

    logic signed [c_PW-1:0] w_x    [3];
    logic signed [c_PW-1:0] w_c    [3];
    logic signed [c_PW-1:0] r_prod [3];
    logic signed [c_SW-1:0] r_sum;
    logic signed [c_SW-1:0] w_shift;
    logic signed [c_SW-1:0] w_res;
    logic [PIXEL_WIDTH-1:0] w_clamp;

    // Both operands are widened to the product width so the multiply is
    // done entirely in signed c_PW-bit arithmetic; the true product fits.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_x[i] = {{(c_PW - PIXEL_WIDTH){1'b0}}, i_x[i]};
            w_c[i] = {{(c_PW - COEF_WIDTH){i_coef[i][COEF_WIDTH-1]}}, i_coef[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_prod[i] <= w_x[i] * w_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= {{2{r_prod[0][c_PW-1]}}, r_prod[0]}
                   + {{2{r_prod[1][c_PW-1]}}, r_prod[1]}
                   + {{2{r_prod[2][c_PW-1]}}, r_prod[2]}
                   + c_ROUND;
        end
    end

    assign w_shift = r_sum >>> COEF_FRAC;

`ifdef COLOR_CORRECT_OFFSET_EN
    // Offset travels alongside the beat so it matches the products it
    // was sampled with.
    logic [PIXEL_WIDTH:0] r_off1;
    logic [PIXEL_WIDTH:0] r_off2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off1 <= '0;
            r_off2 <= '0;
        end else begin
            r_off1 <= i_off;
            r_off2 <= r_off1;
        end
    end

    assign w_res = w_shift + {{(c_SW - PIXEL_WIDTH - 1){r_off2[PIXEL_WIDTH]}}, r_off2};
`else
    assign w_res = w_shift;
`endif

    always_comb begin
        w_clamp = w_res[PIXEL_WIDTH-1:0];
        if (w_res[c_SW-1]) begin
            w_clamp = '0;
        end else if (w_res > c_MAX) begin
            w_clamp = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_pix <= '0;
        end else if (i_load) begin
            o_pix <= w_clamp;
        end
    end

endmodule
`default_nettype wire

// File: rtl/color_correct.sv
`default_nettype none
// ============================================================================
// Module      : color_correct
// Description : Pipelined 3x3 colour-correction matrix, latency 3 cycles.
//               The coefficient bank is double-buffered: it is reloaded from
//               'coefs' on every valid FRAME_START beat, and that beat already
//               uses the new values. enable=0 substitutes the identity matrix
//               (exact pass-through) without changing latency.
// Ports       : clk, reset (sync, active-high), enable
//               dvi/dtypei/ri/gi/bi/meta_datai - input beat
//               coefs                          - 9 signed coefficients
//               offsets                        - 3 signed offsets (optional)
//               dvo/dtypeo/r/g/b/meta_datao    - output beat
// Config      : COLOR_CORRECT_OFFSET_EN adds 'offsets' and an offset bank.
// Revision    : 1.0 - initial release
// ============================================================================
module color_correct
    import color_correct_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int COEF_WIDTH  = 12,
    parameter int COEF_FRAC   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          dvi,
    input  logic [DTYPE_WIDTH-1:0]        dtypei,
    input  logic [PIXEL_WIDTH-1:0]        ri,
    input  logic [PIXEL_WIDTH-1:0]        gi,
    input  logic [PIXEL_WIDTH-1:0]        bi,
    input  logic [DATA_WIDTH-1:0]         meta_datai,
    input  logic [9*COEF_WIDTH-1:0]       coefs,
`ifdef COLOR_CORRECT_OFFSET_EN
    input  logic [3*(PIXEL_WIDTH+1)-1:0]  offsets,
`endif
    output logic                          dvo,
    output logic [DTYPE_WIDTH-1:0]        dtypeo,
    output logic [PIXEL_WIDTH-1:0]        r,
    output logic [PIXEL_WIDTH-1:0]        g,
    output logic [PIXEL_WIDTH-1:0]        b,
    output logic [DATA_WIDTH-1:0]         meta_datao
);

    function automatic logic [9*COEF_WIDTH-1:0] f_identity();
        logic [9*COEF_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) begin
            if (ccm_is_diag(i)) begin
                v[i*COEF_WIDTH +: COEF_WIDTH] = COEF_WIDTH'(1 << COEF_FRAC);
            end
        end
        return v;
    endfunction

    localparam logic [9*COEF_WIDTH-1:0] c_IDENTITY = f_identity();

    logic                         w_fs;
    logic                         w_pix;
    logic [9*COEF_WIDTH-1:0]      r_bank;
    logic [9*COEF_WIDTH-1:0]      w_bank;
    logic [9*COEF_WIDTH-1:0]      w_mat;
    logic [2:0][PIXEL_WIDTH-1:0]  w_x;
    logic [2:0][PIXEL_WIDTH-1:0]  w_out;

    logic                         r_dv1, r_dv2;
    logic                         r_pix1, r_pix2;
    logic [DTYPE_WIDTH-1:0]       r_dt1, r_dt2;
    logic [DATA_WIDTH-1:0]        r_md1, r_md2;

    assign w_fs  = dvi && (dtypei == DTYPE_FRAME_START);
    assign w_pix = dvi && ((dtypei & DTYPE_PIXEL_MASK) != '0);

    // The FRAME_START beat itself must see the incoming bank, so the
    // live 'coefs' bypass the register on that cycle.
    assign w_bank = w_fs ? coefs : r_bank;
    assign w_mat  = enable ? w_bank : c_IDENTITY;
    assign w_x    = {bi, gi, ri};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank <= c_IDENTITY;
        end else if (w_fs) begin
            r_bank <= coefs;
        end
    end

`ifdef COLOR_CORRECT_OFFSET_EN
    logic [3*(PIXEL_WIDTH+1)-1:0] r_offs;
    logic [3*(PIXEL_WIDTH+1)-1:0] w_offs;

    assign w_offs = enable ? (w_fs ? offsets : r_offs) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_offs <= '0;
        end else if (w_fs) begin
            r_offs <= offsets;
        end
    end
`endif

    // Side-channel delay line; matches the three arithmetic stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dv1      <= 1'b0;
            r_dv2      <= 1'b0;
            dvo        <= 1'b0;
            r_pix1     <= 1'b0;
            r_pix2     <= 1'b0;
            r_dt1      <= '0;
            r_dt2      <= '0;
            dtypeo     <= '0;
            r_md1      <= '0;
            r_md2      <= '0;
            meta_datao <= '0;
        end else begin
            r_dv1      <= dvi;
            r_dv2      <= r_dv1;
            dvo        <= r_dv2;
            r_pix1     <= w_pix;
            r_pix2     <= r_pix1;
            r_dt1      <= dtypei;
            r_dt2      <= r_dt1;
            dtypeo     <= r_dt2;
            r_md1      <= meta_datai;
            r_md2      <= r_md1;
            meta_datao <= r_md2;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [2:0][COEF_WIDTH-1:0] w_row;

        for (genvar col = 0; col < 3; col++) begin : g_col
            assign w_row[col] = w_mat[ccm_idx(ch, col)*COEF_WIDTH +: COEF_WIDTH];
        end

        ccm_channel #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH),
            .COEF_FRAC   (COEF_FRAC)
        ) u_ccm_channel (
            .clk    (clk),
            .rst    (reset),
            .i_x    (w_x),
            .i_coef (w_row),
`ifdef COLOR_CORRECT_OFFSET_EN
            .i_off  (w_offs[ch*(PIXEL_WIDTH+1) +: PIXEL_WIDTH+1]),
`endif
            .i_load (r_pix2),
            .o_pix  (w_out[ch])
        );
    end

    assign r = w_out[0];
    assign g = w_out[1];
    assign b = w_out[2];

endmodule
`default_nettype wire

// File: tb/tb_color_correct.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_correct
// Description : Self-checking bench for color_correct. A behavioural model
//               computes each output beat from the matrix equation at input
//               time; a compare process checks the DUT every cycle. Directed
//               scenarios pin the model with hand-computed values, followed
//               by a randomized stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_correct;
    import color_correct_pkg::*;

    localparam int PW = 10;
    localparam int DW = 16;
    localparam int CW = 12;
    localparam int CF = 8;
    localparam int ONE = 1 << CF;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic                   dvi;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic [PW-1:0]          ri, gi, bi;
    logic [DW-1:0]          meta_datai;
    logic [9*CW-1:0]        coefs;
`ifdef COLOR_CORRECT_OFFSET_EN
    logic [3*(PW+1)-1:0]    offsets;
`endif
    logic                   dvo;
    logic [DTYPE_WIDTH-1:0] dtypeo;
    logic [PW-1:0]          r, g, b;
    logic [DW-1:0]          meta_datao;

    color_correct #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(CF)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dvi        (dvi),
        .dtypei     (dtypei),
        .ri         (ri),
        .gi         (gi),
        .bi         (bi),
        .meta_datai (meta_datai),
        .coefs      (coefs),
`ifdef COLOR_CORRECT_OFFSET_EN
        .offsets    (offsets),
`endif
        .dvo        (dvo),
        .dtypeo     (dtypeo),
        .r          (r),
        .g          (g),
        .b          (b),
        .meta_datao (meta_datao)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        bit                     dv;
        logic [DTYPE_WIDTH-1:0] dt;
        logic [DW-1:0]          md;
        int                     px[3];
    } exp_t;

    exp_t q[$];
    int   m_bank[9];
    int   m_offs[3];
    int   m_hold[3];
    bit   started = 1'b0;

    initial begin
        forever begin : model
            exp_t e;
            int   in_px[3];
            int   acc, v;
            @(posedge clk);
            if (reset) begin
                q.delete();
                for (int i = 0; i < 9; i++) m_bank[i] = (i % 4 == 0) ? ONE : 0;
                for (int i = 0; i < 3; i++) begin
                    m_offs[i] = 0;
                    m_hold[i] = 0;
                end
                started = 1'b1;
            end else if (started) begin
                if (dvi && dtypei == DTYPE_FRAME_START) begin
                    for (int i = 0; i < 9; i++) m_bank[i] = int'($signed(coefs[i*CW +: CW]));
`ifdef COLOR_CORRECT_OFFSET_EN
                    for (int i = 0; i < 3; i++) m_offs[i] = int'($signed(offsets[i*(PW+1) +: PW+1]));
`endif
                end
                in_px[0] = int'(ri);
                in_px[1] = int'(gi);
                in_px[2] = int'(bi);
                if (dvi && (dtypei & DTYPE_PIXEL_MASK) != 0) begin
                    for (int c = 0; c < 3; c++) begin
                        if (enable) begin
                            acc = 0;
                            for (int k = 0; k < 3; k++) acc += m_bank[3*c+k] * in_px[k];
                            v = ((acc + ONE/2) >>> CF) + m_offs[c];
                            if (v < 0) v = 0;
                            if (v > (1 << PW) - 1) v = (1 << PW) - 1;
                        end else begin
                            v = in_px[c];
                        end
                        m_hold[c] = v;
                    end
                end
                e.dv = dvi;
                e.dt = dtypei;
                e.md = meta_datai;
                for (int c = 0; c < 3; c++) e.px[c] = m_hold[c];
                q.push_back(e);
            end
        end
    end

    // Compare process: three beats queued means the oldest is now at the output.
    initial begin
        forever begin : compare
            exp_t e;
            @(negedge clk);
            if (started) begin
                if (q.size() >= 3) begin
                    e = q.pop_front();
                    chk("dvo", int'(dvo), int'(e.dv));
                    if (e.dv) begin
                        chk("dtypeo", int'(dtypeo), int'(e.dt));
                        chk("meta_datao", int'(meta_datao), int'(e.md));
                    end
                    chk("r", int'(r), e.px[0]);
                    chk("g", int'(g), e.px[1]);
                    chk("b", int'(b), e.px[2]);
                end else begin
                    chk("dvo_empty", int'(dvo), 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int cset[9];

    task automatic set_ident(input int scale);
        for (int i = 0; i < 9; i++) cset[i] = (i % 4 == 0) ? scale : 0;
    endtask

    task automatic apply_coefs();
        for (int i = 0; i < 9; i++) coefs[i*CW +: CW] = CW'(cset[i]);
    endtask

    task automatic send(input logic [DTYPE_WIDTH-1:0] dt, input int rr, input int gg,
                        input int bb, input logic [DW-1:0] md);
        dvi        = 1'b1;
        dtypei     = dt;
        ri         = PW'(rr);
        gi         = PW'(gg);
        bi         = PW'(bb);
        meta_datai = md;
        @(posedge clk);
        #1;
        dvi    = 1'b0;
        dtypei = '0;
    endtask

    task automatic idle();
        dvi    = 1'b0;
        dtypei = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rgb(input string name, input int er, input int eg, input int eb);
        chk({name, "_r"}, int'(r), er);
        chk({name, "_g"}, int'(g), eg);
        chk({name, "_b"}, int'(b), eb);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios and random stream
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; enable = 1'b1; dvi = 1'b0; dtypei = '0;
        ri = '0; gi = '0; bi = '0; meta_datai = '0;
        set_ident(ONE); apply_coefs();
`ifdef COLOR_CORRECT_OFFSET_EN
        offsets = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dvo", int'(dvo), 0);
        chk("rst_dtypeo", int'(dtypeo), 0);
        chk("rst_meta", int'(meta_datao), 0);
        chk_rgb("rst", 0, 0, 0);
        reset = 1'b0;

        // Identity after reset.
        send(DTYPE_FRAME_START, 0, 0, 0, 16'h0001);
        send(DTYPE_PIXEL, 100, 200, 300, 16'hABCD);
        idle(); idle();
        chk("id_dvo", int'(dvo), 1);
        chk("id_meta", int'(meta_datao), 16'hABCD);
        chk_rgb("identity", 100, 200, 300);

        // Overflow clamp.
        set_ident(ONE); cset[CCM_R_R] = 512; apply_coefs();
        send(DTYPE_FRAME_START, 0, 0, 0, 0);
        send(DTYPE_PIXEL, 1000, 0, 0, 0);
        idle(); idle();
        chk("clamp_hi_r", int'(r), 1023);

        // Negative clamp.
        set_ident(ONE); cset[CCM_R_G] = -256; apply_coefs();
        send(DTYPE_FRAME_START, 0, 0, 0, 0);
        send(DTYPE_PIXEL, 100, 200, 0, 0);
        idle(); idle();
        chk_rgb("clamp_lo", 0, 200, 0);

        // Rounding: 1.5 -> 2, 1.0 -> 1.
        set_ident(ONE); cset[CCM_R_R] = 128; apply_coefs();
        send(DTYPE_FRAME_START, 0, 0, 0, 0);
        send(DTYPE_PIXEL, 3, 0, 0, 0);
        send(DTYPE_PIXEL, 2, 0, 0, 0);
        idle();
        chk("round_3", int'(r), 2);
        idle();
        chk("round_2", int'(r), 1);

        // Double buffering.
        set_ident(ONE); apply_coefs();
        send(DTYPE_FRAME_START, 0, 0, 0, 0);
        set_ident(2*ONE); apply_coefs();
        send(DTYPE_PIXEL, 100, 100, 100, 0);
        idle(); idle();
        chk_rgb("dbuf_old", 100, 100, 100);
        send(DTYPE_FRAME_START, 0, 0, 0, 0);
        send(DTYPE_PIXEL, 100, 100, 100, 0);
        idle(); idle();
        chk_rgb("dbuf_new", 200, 200, 200);

        // Bypass, then hold across a ROW_END beat.
        enable = 1'b0;
        send(DTYPE_PIXEL, 7, 8, 9, 0);
        idle(); idle();
        chk_rgb("bypass", 7, 8, 9);
        enable = 1'b1;
        send(DTYPE_PIXEL, 10, 20, 30, 0);
        send(DTYPE_ROW_END, 500, 500, 500, 16'h0077);
        idle();
        chk_rgb("pre_hold", 20, 40, 60);
        idle();
        chk("hold_dtypeo", int'(dtypeo), int'(DTYPE_ROW_END));
        chk_rgb("hold", 20, 40, 60);

        // Reset mid-frame with beats in flight.
        send(DTYPE_PIXEL, 1, 2, 3, 0);
        send(DTYPE_PIXEL, 4, 5, 6, 0);
        send(DTYPE_PIXEL, 7, 8, 9, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_dvo", int'(dvo), 0);
            idle();
        end
        send(DTYPE_PIXEL, 100, 200, 300, 0);
        idle(); idle();
        chk_rgb("post_rst_ident", 100, 200, 300);

`ifdef COLOR_CORRECT_OFFSET_EN
        set_ident(ONE); apply_coefs();
        offsets = '0;
        offsets[0 +: PW+1] = (PW+1)'(-5);
        send(DTYPE_FRAME_START, 0, 0, 0, 0);
        send(DTYPE_PIXEL, 3, 10, 10, 0);
        idle(); idle();
        chk_rgb("offset", 0, 10, 10);
`endif

        // Randomized stream.
        for (int n = 0; n < 4000; n++) begin
            int sel;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    for (int i = 0; i < 9; i++) cset[i] = int'($urandom_range(0, 4095)) - 2048;
                end else begin
                    for (int i = 0; i < 9; i++)
                        cset[i] = ((i % 4 == 0) ? ONE : 0) + int'($urandom_range(0, 200)) - 100;
                end
                apply_coefs();
`ifdef COLOR_CORRECT_OFFSET_EN
                for (int i = 0; i < 3; i++)
                    offsets[i*(PW+1) +: PW+1] = (PW+1)'(int'($urandom_range(0, 300)) - 150);
`endif
            end
            enable = ($urandom_range(0, 9) != 0);
            dvi    = ($urandom_range(0, 4) != 0);
            sel    = int'($urandom_range(0, 99));
            if (sel < 6)       dtypei = DTYPE_FRAME_START;
            else if (sel < 9)  dtypei = DTYPE_FRAME_END;
            else if (sel < 12) dtypei = DTYPE_ROW_START;
            else if (sel < 15) dtypei = DTYPE_ROW_END;
            else if (sel < 18) dtypei = DTYPE_HEADER;
            else               dtypei = DTYPE_PIXEL;
            ri         = PW'($urandom_range(0, 1023));
            gi         = PW'($urandom_range(0, 1023));
            bi         = PW'($urandom_range(0, 1023));
            meta_datai = DW'($urandom);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        dvi   = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/color_correct.md
# color_correct

- Pipelined 3×3 colour-correction-matrix stage sitting directly downstream of the Bayer bilinear interpolator.
- Consumes its per-pixel `r`/`g`/`b`, `dvo`/`dtypeo`/`meta_datao` stream and produces corrected `r`/`g`/`b` in the same format for the next stage.
- Coefficients are double-buffered and only take effect at a frame boundary, so a frame is never processed with a mix of two matrices.

## Interface
- `PIXEL_WIDTH`, 10, bits per colour channel, in and out.
- `DATA_WIDTH`, 16, width of the meta-data side channel.
- `COEF_WIDTH`, 12, signed two's-complement coefficient width.
- `COEF_FRAC`, 8, fractional bits of a coefficient; 1.0 = 256.
- `clk` in 1: single clock.
- `reset` in 1: reset is synchronous and active-high.
- `enable` in 1: 1 = apply matrix; 0 = identity bypass with the same latency.
- `dvi` in 1: input beat valid.
- `dtypei` in `` `DTYPE_WIDTH ``: beat type from `dtypes.v`.
- `ri`, `gi`, `bi` in `PIXEL_WIDTH`: unsigned input channels.
- `meta_datai` in `DATA_WIDTH`: side-channel data.
- `coefs` in `9*COEF_WIDTH`: coefficient bank.
  - Element i = 3*row+col sits at `[i*COEF_WIDTH +: COEF_WIDTH]`.
  - row = output channel (0 r, 1 g, 2 b); col = input channel (0 r, 1 g, 2 b).
- `dvo` out 1: output beat valid.
- `dtypeo` out `` `DTYPE_WIDTH ``: delayed `dtypei`.
- `r`, `g`, `b` out `PIXEL_WIDTH`: corrected channels.
- `meta_datao` out `DATA_WIDTH`: delayed `meta_datai`.
- `offsets` in `3*(PIXEL_WIDTH+1)`: present only with `COLOR_CORRECT_OFFSET_EN`.
  - Signed per-channel offsets in output LSBs; r at bits [0 +: PIXEL_WIDTH+1].

## Operation
- **Active bank**
  - Internal register copy of `coefs`.
  - Loaded from `coefs` on any cycle with `dvi=1 && dtypei==DTYPE_FRAME_START`.
  - That FRAME_START beat and every later beat use the new bank.
  - `coefs` changes at any other time have no effect.
- **Reset value of active bank:** identity (diagonal 256 << (`COEF_FRAC`-8) scaled to 1.0, off-diagonal 0).
- **Pixel beats:** `dvi=1` and `dtypei & DTYPE_PIXEL_MASK` nonzero.
  - out_c = clamp( round( Σ_col coef[c][col] · in_col ) [+ offset_c] ).
- **Non-pixel beats** (frame/row start/end, header):
  - `dtypeo`, `meta_datao`, `dvo` pass through at the same latency.
  - `r`/`g`/`b` hold their previous values.
- **`dvi=0` beats:** propagate as `dvo=0`; `r`/`g`/`b` hold.
- **`enable`:** sampled on the input beat.
  - `enable=0` outputs `ri`/`gi`/`bi` unchanged at the same latency.
  - Bank loads still occur while `enable=0`.
- **Arithmetic**
  - Input extended to a signed `PIXEL_WIDTH+1`-bit value.
  - Product: `PIXEL_WIDTH+COEF_WIDTH+1` bits signed.
  - Sum: product width + 2 guard bits; no intermediate overflow possible.
  - Rounding: add 2^(`COEF_FRAC`-1), then arithmetic shift right by `COEF_FRAC` (round half up toward +∞).
  - Clamp: result <0 → 0; result >2^`PIXEL_WIDTH`-1 → 2^`PIXEL_WIDTH`-1.
- No backpressure: one beat in per cycle, one beat out per cycle, and every input cycle produces an output cycle.

## Timing
- Fixed latency of 3 cycles from input beat to output beat, identical for all beat types and both `enable` settings.
- Pipeline stages:
  - S1: register inputs and the 9 products.
  - S2: register three sums plus rounding constant.
  - S3: shift, offset, clamp, and register outputs.
- Reset values: `dvo`=0, `dtypeo`=0, `r`=`g`=`b`=0, `meta_datao`=0; all pipeline valid bits 0.
- Reset mid-stream: all in-flight beats are discarded; `dvo`=0 on the cycle after `reset` is seen high; active bank returns to identity.
- Back-to-back FRAME_START beats: each one reloads the bank. Beats already in S1–S3 keep the coefficients they were multiplied with.

## Configuration
- `COLOR_CORRECT_OFFSET_EN` defined:
  - Adds the `offsets` port and a double-buffered offset bank loaded with the coefficients at FRAME_START.
  - Offset bank resets to 0.
  - Offset is added after the shift and before the clamp.
  - Offsets are ignored when `enable=0`.
- `COLOR_CORRECT_OFFSET_EN` not defined: no port, no adder; latency unchanged.

## Structure
- `dtypes.v` supplies the beat-type constants, `` `DTYPE_WIDTH `` and the pack/unpack macros.
- New shared header `color_correct_defs.v` holds:
  - the identity-bank constant;
  - the coefficient index constants (R_R … B_B);
  - the rounding-constant macro.
- One sub-module, `ccm_channel`:
  - one output channel's three multiplies, sum, round, offset and clamp across S1–S3;
  - instantiated three times.
- Parent owns the bank registers, the `dtype`/meta/valid delay line and the hold logic.

## Test plan
All scenarios use `PIXEL_WIDTH`=10 and `COEF_FRAC`=8.
- **Identity after reset:** FRAME_START, then pixel (100,200,300) → pixel out (100,200,300) exactly 3 cycles later; `meta_datao` matches.
- **Overflow clamp:** bank c[0][0]=512 loaded at FRAME_START, input r=1000 → r=1023. Negative clamp: c[0][0]=256, c[0][1]=-256, input (100,200,·) → r=0.
- **Rounding:** c[0][0]=128, r=3 → r=2 (1.5 rounds up); r=2 → r=1.
- **Double buffering:** change `coefs` to 2×identity mid-frame → pixels unchanged until the next FRAME_START; from that beat, (100,100,100) → (200,200,200).
- **Bypass and hold:** `enable`=0 with a non-identity bank → pixels pass unchanged. A ROW_END beat between pixels leaves `r`/`g`/`b` held at the prior pixel's values while `dtypeo`=ROW_END.
- **Reset mid-frame and offsets:**
  - Assert `reset` with 3 beats in flight → no `dvo` afterwards, and the bank is identity again.
  - With `COLOR_CORRECT_OFFSET_EN`, offset_r=-5 and r=3 → r=0.
